// File: rtl/geiger_emu_pkg.sv
// Shared constants and helpers for the Geiger pulse emulator and its LFSR.
package geiger_emu_pkg;

  // Emitter state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DEAD  = 2'd2
  } geiger_state_e;

  // Galois feedback mask (taps 16,14,13,11).
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Random-emission thresholds, in events per 65536 cycles.
  localparam logic [15:0] THRESH_00 = 16'd0;
  localparam logic [15:0] THRESH_01 = 16'd1;
  localparam logic [15:0] THRESH_10 = 16'd16;
  localparam logic [15:0] THRESH_11 = 16'd256;

  // Pulses emitted per trig-initiated burst.
  localparam int unsigned BURST_LEN = 4;

  // Map the board switch setting to a hit threshold.
  function automatic logic [15:0] rate_thresh(input logic [1:0] sel);
    logic [15:0] t;
    case (sel)
      2'b00:   t = THRESH_00;
      2'b01:   t = THRESH_01;
      2'b10:   t = THRESH_10;
      2'b11:   t = THRESH_11;
      default: t = THRESH_00;
    endcase
    return t;
  endfunction

  // One right-shifting Galois step; zero state never reachable from nonzero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/geiger_lfsr.sv
// 16-bit Galois LFSR, loads SEED on reset and advances while step is high.
module geiger_lfsr
  import geiger_emu_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_r;

  // Shift register: reseed on reset, advance on step, otherwise hold.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      q_r <= SEED;
    end else if (step) begin
      q_r <= lfsr_next(q_r);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/geiger_pulse_emulator.sv
// Geiger-tube pulse emulator: random or manual events, each a fixed-width
// high pulse followed by an enforced dead time.
// Optional build macro GEIGER_EMU_BURST_EN: a trig-initiated start emits a
// burst of BURST_LEN pulses, each with its own full dead time.
module geiger_pulse_emulator
  import geiger_emu_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 100,
  parameter int unsigned DEAD_CYCLES  = 5000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] rate_sel,
  input  logic       trig,
  output logic       pulse_out,
  output logic       busy,
  output logic [7:0] emitted_count
);

  localparam logic [1:0]  IDLE      = ST_IDLE;
  localparam logic [1:0]  PULSE     = ST_PULSE;
  localparam logic [1:0]  DEAD      = ST_DEAD;
  localparam logic [31:0] PULSE_LD  = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] DEAD_LD   = 32'(DEAD_CYCLES - 1);

  logic [15:0] lfsr_q_s;
  logic        hit_s;
  logic        start_s;

  logic [1:0]  state_r,  state_nx_s;
  logic [31:0] cnt_r,    cnt_nx_s;
  logic        pulse_r,  pulse_nx_s;
  logic        busy_r;
  logic [7:0]  count_r,  count_nx_s;
`ifdef GEIGER_EMU_BURST_EN
  localparam logic [1:0]  BURST_LD  = 2'(BURST_LEN - 1);
  logic [1:0]  burst_r,  burst_nx_s;
`endif

  geiger_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .sys_clk (sys_clk),
    .rst     (rst),
    .step    (en),
    .q       (lfsr_q_s)
  );

  assign hit_s   = en && (lfsr_q_s < rate_thresh(rate_sel));
  assign start_s = (state_r == IDLE) && (hit_s || trig);

  // Next-state logic; requests outside IDLE fall through and are dropped.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    pulse_nx_s = pulse_r;
    count_nx_s = count_r;
`ifdef GEIGER_EMU_BURST_EN
    burst_nx_s = burst_r;
`endif
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nx_s = PULSE;
          cnt_nx_s   = PULSE_LD;
          pulse_nx_s = 1'b1;
          count_nx_s = count_r + 8'd1;
`ifdef GEIGER_EMU_BURST_EN
          burst_nx_s = trig ? BURST_LD : 2'd0;
`endif
        end else begin
          pulse_nx_s = 1'b0;
        end
      end
      PULSE: begin
        if (cnt_r == 32'd0) begin
          state_nx_s = DEAD;
          cnt_nx_s   = DEAD_LD;
          pulse_nx_s = 1'b0;
        end else begin
          cnt_nx_s   = cnt_r - 32'd1;
          pulse_nx_s = 1'b1;
        end
      end
      DEAD: begin
        if (cnt_r == 32'd0) begin
`ifdef GEIGER_EMU_BURST_EN
          if (burst_r != 2'd0) begin
            state_nx_s = PULSE;
            cnt_nx_s   = PULSE_LD;
            pulse_nx_s = 1'b1;
            count_nx_s = count_r + 8'd1;
            burst_nx_s = burst_r - 2'd1;
          end else begin
            state_nx_s = IDLE;
            pulse_nx_s = 1'b0;
          end
`else
          state_nx_s = IDLE;
          pulse_nx_s = 1'b0;
`endif
        end else begin
          cnt_nx_s   = cnt_r - 32'd1;
          pulse_nx_s = 1'b0;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 32'd0;
        pulse_nx_s = 1'b0;
      end
    endcase
  end

  // State, phase counter and registered outputs; reset drops any event.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 32'd0;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      count_r <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      pulse_r <= pulse_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      count_r <= count_nx_s;
    end
  end

`ifdef GEIGER_EMU_BURST_EN
  // Remaining pulses of the current burst; reset aborts the burst.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      burst_r <= 2'd0;
    end else begin
      burst_r <= burst_nx_s;
    end
  end
`endif

  assign pulse_out     = pulse_r;
  assign busy          = busy_r;
  assign emitted_count = count_r;

endmodule

// File: tb/tb_geiger_pulse_emulator.sv
// Directed self-checking bench for geiger_pulse_emulator (PULSE=4, DEAD=10).
module tb_geiger_pulse_emulator;

  localparam int P = 4;
  localparam int D = 10;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] rate_sel = 2'b00;
  logic       trig = 1'b0;
  logic       pulse_out;
  logic       busy;
  logic [7:0] emitted_count;

  int n_vec = 0;
  int n_err = 0;

  // rising-edge monitor state
  int cyc = 0;
  int rise_cnt = 0;
  int last_rise = -1;
  int min_gap = 1000000;
  int max_gap = 0;
  logic prev_pulse = 1'b0;

  geiger_pulse_emulator #(
    .PULSE_CYCLES (P),
    .DEAD_CYCLES  (D),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .en            (en),
    .rate_sel      (rate_sel),
    .trig          (trig),
    .pulse_out     (pulse_out),
    .busy          (busy),
    .emitted_count (emitted_count)
  );

  always #5 sys_clk = ~sys_clk;

  // pulse_out rising-edge tracker, sampled 1 time unit after each clock edge
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      cyc = cyc + 1;
      if (pulse_out && !prev_pulse) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < min_gap) min_gap = cyc - last_rise;
          if (cyc - last_rise > max_gap) max_gap = cyc - last_rise;
        end
        last_rise = cyc;
        rise_cnt = rise_cnt + 1;
      end
      prev_pulse = pulse_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
  endtask

  task automatic clear_mon();
    rise_cnt = 0;
    last_rise = -1;
    min_gap = 1000000;
    max_gap = 0;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] q);
    logic [15:0] r;
    r = q >> 1;
    if (q[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    logic seen;
    do_reset();
    n_vec++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || emitted_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state: pulse=%b busy=%b count=%0d, required 0 0 0",
               pulse_out, busy, emitted_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (pulse_out !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick(1);
    end
    n_vec++;
    if (seen !== 1'b0 || emitted_count !== 8'd0) begin
      n_err++;
      $display("FAIL idle_quiet: activity=%b count=%0d, required 0 0", seen, emitted_count);
    end
  endtask

  task automatic test_single_trig();
    logic bad;
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < P; i++) begin
      if (pulse_out !== 1'b1 || busy !== 1'b1) bad = 1'b1;
      tick(1);
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL single_high: pulse not high/busy for %0d cycles (bad=%b), required 0", P, bad);
    end
    n_vec++;
    if (emitted_count !== 8'd1) begin
      n_err++;
      $display("FAIL single_count: count=%0d, required 1", emitted_count);
    end
    bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (pulse_out !== 1'b0) bad = 1'b1;
      trig = (i == 1) ? 1'b1 : 1'b0;
      tick(1);
    end
    trig = 1'b0;
    n_vec++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL dead_low: pulse high during dead time (bad=%b), required 0", bad);
    end
    tick(8);
    n_vec++;
    if (emitted_count !== 8'd1 || busy !== 1'b0 || pulse_out !== 1'b0) begin
      n_err++;
      $display("FAIL trig_in_dead: count=%0d busy=%b pulse=%b, required 1 0 0",
               emitted_count, busy, pulse_out);
    end
  endtask

  task automatic test_held_trig();
    clear_mon();
    trig = 1'b1;
    tick(100);
    trig = 1'b0;
    tick(20);
    n_vec++;
    if (rise_cnt !== 7 || emitted_count !== 8'd8) begin
      n_err++;
      $display("FAIL held_trig: pulses=%0d count=%0d, required 7 8", rise_cnt, emitted_count);
    end
    n_vec++;
    if (min_gap < P + D) begin
      n_err++;
      $display("FAIL held_spacing: min gap=%0d, required >=%0d", min_gap, P + D);
    end
  endtask

  task automatic test_random();
    logic [15:0] m_lfsr;
    int          next_ok;
    int          exp_cnt;
    do_reset();
    clear_mon();
    m_lfsr = 16'hACE1;
    next_ok = 0;
    exp_cnt = 0;
    rate_sel = 2'b11;
    en = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      if (i >= next_ok && m_lfsr < 16'd256) begin
        exp_cnt = exp_cnt + 1;
        next_ok = i + P + D + 1;
      end
      m_lfsr = ref_step(m_lfsr);
      tick(1);
    end
    en = 1'b0;
    tick(20);
    n_vec++;
    if (emitted_count !== exp_cnt[7:0]) begin
      n_err++;
      $display("FAIL random_count: count=%0d, required %0d (total %0d)",
               emitted_count, exp_cnt[7:0], exp_cnt);
    end
    n_vec++;
    if (dut.u_lfsr.q !== m_lfsr) begin
      n_err++;
      $display("FAIL random_lfsr: lfsr=%h, required %h", dut.u_lfsr.q, m_lfsr);
    end
    n_vec++;
    if (min_gap < P + D || rise_cnt < 2) begin
      n_err++;
      $display("FAIL random_spacing: min gap=%0d rises=%0d, required gap>=%0d rises>=2",
               min_gap, rise_cnt, P + D);
    end
    rate_sel = 2'b00;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
      tick(P + D + 1);
      if (i == 254) begin
        n_vec++;
        if (emitted_count !== 8'd255) begin
          n_err++;
          $display("FAIL count_255: count=%0d, required 255", emitted_count);
        end
      end
    end
    n_vec++;
    if (emitted_count !== 8'd0) begin
      n_err++;
      $display("FAIL count_wrap: count=%0d, required 0", emitted_count);
    end
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(1);
    n_vec++;
    if (pulse_out !== 1'b1 || emitted_count !== 8'd1) begin
      n_err++;
      $display("FAIL pre_reset: pulse=%b count=%0d, required 1 1", pulse_out, emitted_count);
    end
    rst = 1'b1;
    tick(1);
    n_vec++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || emitted_count !== 8'd0 ||
        dut.u_lfsr.q !== 16'hACE1) begin
      n_err++;
      $display("FAIL midpulse_reset: pulse=%b busy=%b count=%0d lfsr=%h, required 0 0 0 ace1",
               pulse_out, busy, emitted_count, dut.u_lfsr.q);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_burst();
    do_reset();
    clear_mon();
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(80);
    n_vec++;
    if (rise_cnt !== 4 || emitted_count !== 8'd4 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL burst_count: pulses=%0d count=%0d busy=%b, required 4 4 0",
               rise_cnt, emitted_count, busy);
    end
    n_vec++;
    if (min_gap !== P + D || max_gap !== P + D) begin
      n_err++;
      $display("FAIL burst_spacing: gaps %0d..%0d, required %0d", min_gap, max_gap, P + D);
    end
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    tick(20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_mon();
    tick(80);
    n_vec++;
    if (rise_cnt !== 0 || emitted_count !== 8'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL burst_abort: pulses=%0d count=%0d busy=%b, required 0 0 0",
               rise_cnt, emitted_count, busy);
    end
  endtask

  initial begin
    test_reset();
`ifdef GEIGER_EMU_BURST_EN
    test_burst();
`else
    test_single_trig();
    test_held_trig();
    test_wrap_and_reset();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
